// File: rtl/axi_stream_monitor_pkg.sv
// Package for the AXI4-stream monitor.
// Pulls in the shared flag definitions, declares the packet-tracking state
// type and a priority encoder that turns a flag vector into a first-error code.
package axi_stream_monitor_pkg;

`include "axi_stream_monitor_defs.vh"

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    // Lowest set flag index plus one; 0 when no flag is set.
    function automatic logic [2:0] first_err_code(input logic [ERR_W-1:0] e);
        first_err_code = 3'd0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (e[i]) first_err_code = 3'(i + 1);
        end
    endfunction

endpackage

// File: rtl/axi_stream_monitor_if.sv
// AXI4-stream bundle.
// Signals: tvalid, tready, tdata (8*BW), tkeep (BW), tlast.
// Modports: master drives the payload, slave drives tready, monitor only
// observes everything.
interface axi_stream_monitor_if #(
    parameter int BW = 4
) ();
    logic              tvalid;
    logic              tready;
    logic [8*BW-1:0]   tdata;
    logic [BW-1:0]     tkeep;
    logic              tlast;

    modport master  (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave   (input tvalid, tdata, tkeep, tlast, output tready);
    modport monitor (input tvalid, tready, tdata, tkeep, tlast);
endinterface

// File: rtl/axi_stream_keep_check.sv
// Combinational tkeep analysis shared by the byte counter and packing check.
// Ports:
//   tkeep     in  BW    byte-keep of the current beat
//   tlast     in  1     last flag of the current beat
//   popcount  out PC_W  number of set tkeep bits
//   packed_ok out 1     non-last beat: all ones; last beat: non-zero and
//                       contiguous from bit 0
module axi_stream_keep_check #(
    parameter int BW   = 4,
    parameter int PC_W = $clog2(BW + 1)
) (
    input  logic [BW-1:0]   tkeep,
    input  logic            tlast,
    output logic [PC_W-1:0] popcount,
    output logic            packed_ok
);
    logic [BW-1:0] keep_inc;
    logic          contiguous;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < BW; i++) begin
            popcount = popcount + PC_W'(tkeep[i]);
        end
        // A mask of the form 0..01..1 plus one has no bit in common with itself.
        keep_inc   = tkeep + BW'(1);
        contiguous = ((tkeep & keep_inc) == '0);
        packed_ok  = tlast ? ((tkeep != '0) && contiguous) : (tkeep == '1);
    end
endmodule

// File: rtl/axi_stream_monitor_defs.vh
// Shared definitions for the AXI4-stream monitor.
// Bit positions of the sticky violation flags and the flag vector width.
`ifndef AXI_STREAM_MONITOR_DEFS_VH
`define AXI_STREAM_MONITOR_DEFS_VH

localparam int ERR_VALID_WITHDRAW = 0;
localparam int ERR_PAYLOAD_CHANGE = 1;
localparam int ERR_READY_WITHDRAW = 2;
localparam int ERR_NOT_PACKED     = 3;
localparam int ERR_PKT_TOO_LONG   = 4;
localparam int ERR_STALL_TIMEOUT  = 5;
localparam int ERR_W              = 6;

`endif

// File: rtl/axi_stream_monitor.sv
// Passive AXI4-stream protocol monitor.
// Taps one stream and latches protocol violations into sticky flags with
// first-error capture, and keeps saturating beat/packet/byte statistics.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous clear of flags, capture, counters, packet state
//   s               tapped stream (monitor modport, observe only)
//   err_flags       sticky violation flags (see axi_stream_monitor_defs.vh)
//   err_any         registered OR of err_flags
//   err_first_code  first flag index plus 1, 0 while no error
//   err_first_beat  beat_cnt at the moment the first error latched
//   beat_cnt        handshaked beats
//   pkt_cnt         handshaked beats with tlast
//   byte_cnt        sum of tkeep popcounts over handshaked beats
module axi_stream_monitor
    import axi_stream_monitor_pkg::*;
#(
    parameter int BW                 = 4,
    parameter int CHECK_SLAVE_STABLE = 0,
    parameter int CHECK_PACKED       = 1,
    parameter int MAX_PKT_BEATS      = 0,
    parameter int STALL_LIMIT        = 0,
    parameter int CNT_W              = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    axi_stream_monitor_if.monitor s,
    output logic [ERR_W-1:0] err_flags,
    output logic             err_any,
    output logic [2:0]       err_first_code,
    output logic [CNT_W-1:0] err_first_beat,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] byte_cnt
);
    localparam int PC_W = $clog2(BW + 1);
    localparam int PB_W = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 2) : 1;
    localparam int SC_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [PB_W-1:0] PB_SAT = PB_W'(MAX_PKT_BEATS + 1);
    localparam logic [SC_W-1:0] SC_SAT = SC_W'(STALL_LIMIT);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Prior-sample registers: only rst touches these, so a stall that
    // straddles clear is still checked for stability.
    logic            prev_tvalid_q, prev_tready_q, prev_tlast_q;
    logic [8*BW-1:0] prev_tdata_q;
    logic [BW-1:0]   prev_tkeep_q;

    pkt_state_e      state_q, state_d;
    logic [PB_W-1:0] pkt_beats_q, pkt_beats_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [ERR_W-1:0] err_flags_q, err_flags_d;
    logic             err_any_q, err_any_d;
    logic [2:0]       err_first_code_q, err_first_code_d;
    logic [CNT_W-1:0] err_first_beat_q, err_first_beat_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic             hs, stall, packed_ok;
    logic [PC_W-1:0]  popcount;
    logic [ERR_W-1:0] err_now;

    axi_stream_keep_check #(
        .BW   (BW),
        .PC_W (PC_W)
    ) u_keep_check (
        .tkeep     (s.tkeep),
        .tlast     (s.tlast),
        .popcount  (popcount),
        .packed_ok (packed_ok)
    );

    // Violation detection for the current sample
    always_comb begin
        hs      = s.tvalid & s.tready;
        stall   = s.tvalid & ~s.tready;
        err_now = '0;
        err_now[ERR_VALID_WITHDRAW] = prev_tvalid_q & ~prev_tready_q & ~s.tvalid;
        err_now[ERR_PAYLOAD_CHANGE] = prev_tvalid_q & ~prev_tready_q & s.tvalid &
                                      ((s.tdata != prev_tdata_q) |
                                       (s.tkeep != prev_tkeep_q) |
                                       (s.tlast != prev_tlast_q));
        err_now[ERR_READY_WITHDRAW] = (CHECK_SLAVE_STABLE != 0) & prev_tready_q &
                                      ~prev_tvalid_q & ~s.tready;
        err_now[ERR_NOT_PACKED]     = (CHECK_PACKED != 0) & s.tvalid & ~packed_ok;
        // pkt_beats saturates one past the limit, so this matches only once per packet.
        err_now[ERR_PKT_TOO_LONG]   = (MAX_PKT_BEATS != 0) & hs &
                                      (pkt_beats_q == PB_W'(MAX_PKT_BEATS));
        err_now[ERR_STALL_TIMEOUT]  = (STALL_LIMIT != 0) & stall &
                                      (stall_cnt_q == SC_W'(STALL_LIMIT - 1));
    end

    // Packet tracking FSM
    always_comb begin
        state_d     = state_q;
        pkt_beats_d = pkt_beats_q;
        if (clear) begin
            state_d     = ST_IDLE;
            pkt_beats_d = '0;
        end else if (hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (!s.tlast) begin
                        state_d     = ST_IN_PKT;
                        pkt_beats_d = PB_W'(1);
                    end
                end
                ST_IN_PKT: begin
                    if (s.tlast) begin
                        state_d     = ST_IDLE;
                        pkt_beats_d = '0;
                    end else if (pkt_beats_q != PB_SAT) begin
                        pkt_beats_d = pkt_beats_q + PB_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    pkt_beats_d = '0;
                end
            endcase
        end
    end

    // Stall counter, flags, first-error capture and statistics
    always_comb begin
        stall_cnt_d      = '0;
        err_flags_d      = '0;
        err_first_code_d = err_first_code_q;
        err_first_beat_d = err_first_beat_q;
        beat_cnt_d       = beat_cnt_q;
        pkt_cnt_d        = pkt_cnt_q;
        byte_cnt_d       = byte_cnt_q;
        if (clear) begin
            err_first_code_d = '0;
            err_first_beat_d = '0;
            beat_cnt_d       = '0;
            pkt_cnt_d        = '0;
            byte_cnt_d       = '0;
        end else begin
            if (stall) begin
                stall_cnt_d = (stall_cnt_q == SC_SAT) ? stall_cnt_q : stall_cnt_q + SC_W'(1);
            end
            err_flags_d = err_flags_q | err_now;
            if ((err_first_code_q == 3'd0) && (err_now != '0)) begin
                err_first_code_d = first_err_code(err_now);
                err_first_beat_d = beat_cnt_q;
            end
            if (hs) begin
                beat_cnt_d = sat_add(beat_cnt_q, CNT_W'(1));
                byte_cnt_d = sat_add(byte_cnt_q, CNT_W'(popcount));
                if (s.tlast) pkt_cnt_d = sat_add(pkt_cnt_q, CNT_W'(1));
            end
        end
        err_any_d = |err_flags_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_tvalid_q    <= 1'b0;
            prev_tready_q    <= 1'b0;
            prev_tlast_q     <= 1'b0;
            prev_tdata_q     <= '0;
            prev_tkeep_q     <= '0;
            state_q          <= ST_IDLE;
            pkt_beats_q      <= '0;
            stall_cnt_q      <= '0;
            err_flags_q      <= '0;
            err_any_q        <= 1'b0;
            err_first_code_q <= '0;
            err_first_beat_q <= '0;
            beat_cnt_q       <= '0;
            pkt_cnt_q        <= '0;
            byte_cnt_q       <= '0;
        end else begin
            prev_tvalid_q    <= s.tvalid;
            prev_tready_q    <= s.tready;
            prev_tlast_q     <= s.tlast;
            prev_tdata_q     <= s.tdata;
            prev_tkeep_q     <= s.tkeep;
            state_q          <= state_d;
            pkt_beats_q      <= pkt_beats_d;
            stall_cnt_q      <= stall_cnt_d;
            err_flags_q      <= err_flags_d;
            err_any_q        <= err_any_d;
            err_first_code_q <= err_first_code_d;
            err_first_beat_q <= err_first_beat_d;
            beat_cnt_q       <= beat_cnt_d;
            pkt_cnt_q        <= pkt_cnt_d;
            byte_cnt_q       <= byte_cnt_d;
        end
    end

    assign err_flags      = err_flags_q;
    assign err_any        = err_any_q;
    assign err_first_code = err_first_code_q;
    assign err_first_beat = err_first_beat_q;
    assign beat_cnt       = beat_cnt_q;
    assign pkt_cnt        = pkt_cnt_q;
    assign byte_cnt       = byte_cnt_q;
endmodule

// File: tb/tb_axi_stream_monitor.sv
// Testbench for axi_stream_monitor. Two monitors tap one stream:
//   dut_a: packing check on, slave check off, MAX_PKT_BEATS=4, STALL_LIMIT=3
//   dut_b: packing check off, slave check on, length/stall checks off
module tb_axi_stream_monitor;
    localparam int BW    = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_stream_monitor_if #(.BW(BW)) sif ();

    logic [5:0]       a_flags, b_flags;
    logic             a_any, b_any;
    logic [2:0]       a_code, b_code;
    logic [CNT_W-1:0] a_fbeat, a_beat, a_pkt, a_byte;
    logic [CNT_W-1:0] b_fbeat, b_beat, b_pkt, b_byte;

    axi_stream_monitor #(
        .BW(BW), .CHECK_SLAVE_STABLE(0), .CHECK_PACKED(1),
        .MAX_PKT_BEATS(4), .STALL_LIMIT(3), .CNT_W(CNT_W)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .s(sif.monitor),
        .err_flags(a_flags), .err_any(a_any), .err_first_code(a_code),
        .err_first_beat(a_fbeat), .beat_cnt(a_beat), .pkt_cnt(a_pkt), .byte_cnt(a_byte)
    );

    axi_stream_monitor #(
        .BW(BW), .CHECK_SLAVE_STABLE(1), .CHECK_PACKED(0),
        .MAX_PKT_BEATS(0), .STALL_LIMIT(0), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .s(sif.monitor),
        .err_flags(b_flags), .err_any(b_any), .err_first_code(b_code),
        .err_first_beat(b_fbeat), .beat_cnt(b_beat), .pkt_cnt(b_pkt), .byte_cnt(b_byte)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        sif.tvalid = 1'b0;
        sif.tready = 1'b1;
        sif.tdata  = '0;
        sif.tkeep  = '0;
        sif.tlast  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        sif.tvalid = 1'b1;
        sif.tready = 1'b1;
        sif.tdata  = d;
        sif.tkeep  = k;
        sif.tlast  = l;
        tick;
    endtask

    task automatic do_clear;
        go_idle;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    task automatic test_reset;
        go_idle;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL reset_flags got %b want 000000", a_flags); end
        checks++; if (a_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", a_any); end
        checks++; if (a_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", a_code); end
        checks++; if (a_fbeat !== 32'd0) begin errors++; $display("FAIL reset_fbeat got %0d want 0", a_fbeat); end
        checks++; if (a_beat !== 32'd0 || a_pkt !== 32'd0 || a_byte !== 32'd0) begin
            errors++; $display("FAIL reset_cnts got %0d/%0d/%0d want 0/0/0", a_beat, a_pkt, a_byte); end
        rst = 1'b0;
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL post_reset_flags got %b want 000000", a_flags); end
    endtask

    task automatic test_legal_traffic;
        int stalls;
        logic first;
        logic rdy;
        do_clear;
        first = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sif.tvalid = 1'b1;
            sif.tdata  = 32'hA0 + 32'(i);
            sif.tkeep  = (i == 6) ? 4'b0011 : 4'b1111;
            sif.tlast  = (i == 3 || i == 4 || i == 6);
            stalls = 0;
            for (int t = 0; t < 4; t++) begin
                rdy = (first || stalls == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                first = 1'b0;
                sif.tready = rdy;
                tick;
                if (rdy) break;
                stalls++;
            end
        end
        go_idle;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL legal_flags_a got %b want 000000", a_flags); end
        checks++; if (a_code !== 3'd0) begin errors++; $display("FAIL legal_code_a got %0d want 0", a_code); end
        checks++; if (a_beat !== 32'd7) begin errors++; $display("FAIL legal_beat_a got %0d want 7", a_beat); end
        checks++; if (a_pkt !== 32'd3) begin errors++; $display("FAIL legal_pkt_a got %0d want 3", a_pkt); end
        checks++; if (a_byte !== 32'd26) begin errors++; $display("FAIL legal_byte_a got %0d want 26", a_byte); end
        checks++; if (b_flags !== 6'd0) begin errors++; $display("FAIL legal_flags_b got %b want 000000", b_flags); end
        checks++; if (b_beat !== 32'd7 || b_pkt !== 32'd3 || b_byte !== 32'd26) begin
            errors++; $display("FAIL legal_cnts_b got %0d/%0d/%0d want 7/3/26", b_beat, b_pkt, b_byte); end
    endtask

    task automatic test_payload_change;
        do_clear;
        beat(32'h1, 4'hF, 1'b0);
        beat(32'h2, 4'hF, 1'b0);
        beat(32'h3, 4'hF, 1'b0);
        beat(32'h4, 4'hF, 1'b1);
        beat(32'h5, 4'hF, 1'b0);
        checks++; if (a_beat !== 32'd5) begin errors++; $display("FAIL pc_pre_beat got %0d want 5", a_beat); end
        sif.tvalid = 1'b1; sif.tready = 1'b0; sif.tdata = 32'h11; sif.tkeep = 4'hF; sif.tlast = 1'b0;
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL pc_stall_flags got %b want 000000", a_flags); end
        sif.tdata = 32'h22;
        tick;
        checks++; if (a_flags !== 6'b000010) begin errors++; $display("FAIL pc_flags_a got %b want 000010", a_flags); end
        checks++; if (a_any !== 1'b1) begin errors++; $display("FAIL pc_any got %b want 1", a_any); end
        checks++; if (a_code !== 3'd2) begin errors++; $display("FAIL pc_code got %0d want 2", a_code); end
        checks++; if (a_fbeat !== 32'd5) begin errors++; $display("FAIL pc_fbeat got %0d want 5", a_fbeat); end
        checks++; if (b_flags !== 6'b000010) begin errors++; $display("FAIL pc_flags_b got %b want 000010", b_flags); end
        sif.tready = 1'b1;
        tick;
        beat(32'h33, 4'hF, 1'b1);
        go_idle;
    endtask

    task automatic test_not_packed;
        do_clear;
        beat(32'h77, 4'b0101, 1'b1);
        go_idle;
        checks++; if (a_flags !== 6'b001000) begin errors++; $display("FAIL np_flags_a got %b want 001000", a_flags); end
        checks++; if (a_code !== 3'd4) begin errors++; $display("FAIL np_code got %0d want 4", a_code); end
        checks++; if (a_byte !== 32'd2 || a_pkt !== 32'd1) begin
            errors++; $display("FAIL np_cnts got %0d/%0d want 2/1", a_byte, a_pkt); end
        checks++; if (b_flags !== 6'd0) begin errors++; $display("FAIL np_flags_b got %b want 000000", b_flags); end
    endtask

    task automatic test_packed_edges;
        do_clear;
        beat(32'h1, 4'b1111, 1'b0);
        beat(32'h2, 4'b0111, 1'b1);
        go_idle;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL pk_legal_flags got %b want 000000", a_flags); end
        checks++; if (a_byte !== 32'd7) begin errors++; $display("FAIL pk_legal_byte got %0d want 7", a_byte); end
        do_clear;
        beat(32'h3, 4'b0000, 1'b1);
        go_idle;
        checks++; if (a_flags !== 6'b001000) begin errors++; $display("FAIL pk_zero_flags got %b want 001000", a_flags); end
        checks++; if (a_byte !== 32'd0 || a_pkt !== 32'd1) begin
            errors++; $display("FAIL pk_zero_cnts got %0d/%0d want 0/1", a_byte, a_pkt); end
        do_clear;
        beat(32'h4, 4'b0111, 1'b0);
        checks++; if (a_flags !== 6'b001000) begin errors++; $display("FAIL pk_nonlast_flags got %b want 001000", a_flags); end
        beat(32'h5, 4'b1111, 1'b1);
        go_idle;
    endtask

    task automatic test_pkt_too_long;
        do_clear;
        for (int i = 1; i <= 6; i++) begin
            beat(32'(i), 4'hF, (i == 6));
            if (i <= 4) begin
                checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL len_beat%0d got %b want 000000", i, a_flags); end
            end else begin
                checks++; if (a_flags !== 6'b010000) begin errors++; $display("FAIL len_beat%0d got %b want 010000", i, a_flags); end
            end
            if (i == 5) begin
                checks++; if (a_code !== 3'd5 || a_fbeat !== 32'd4) begin
                    errors++; $display("FAIL len_capture got %0d/%0d want 5/4", a_code, a_fbeat); end
            end
        end
        beat(32'h7, 4'hF, 1'b0);
        beat(32'h8, 4'hF, 1'b1);
        go_idle;
        checks++; if (a_pkt !== 32'd2 || a_beat !== 32'd8) begin
            errors++; $display("FAIL len_cnts got %0d/%0d want 2/8", a_pkt, a_beat); end
        checks++; if (a_flags !== 6'b010000) begin errors++; $display("FAIL len_final got %b want 010000", a_flags); end
        checks++; if (b_flags !== 6'd0) begin errors++; $display("FAIL len_flags_b got %b want 000000", b_flags); end
    endtask

    task automatic test_stall_timeout;
        do_clear;
        sif.tvalid = 1'b1; sif.tready = 1'b0; sif.tdata = 32'h55; sif.tkeep = 4'hF; sif.tlast = 1'b1;
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL st_edge1 got %b want 000000", a_flags); end
        checks++; if (b_flags !== 6'b000100 || b_any !== 1'b1) begin
            errors++; $display("FAIL rw_flags_b got %b/%b want 000100/1", b_flags, b_any); end
        checks++; if (b_code !== 3'd3 || b_fbeat !== 32'd0) begin
            errors++; $display("FAIL rw_capture_b got %0d/%0d want 3/0", b_code, b_fbeat); end
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL st_edge2 got %b want 000000", a_flags); end
        sif.tready = 1'b1;
        tick;
        sif.tready = 1'b0; sif.tdata = 32'h66;
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL st_edge4 got %b want 000000", a_flags); end
        tick;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL st_edge5 got %b want 000000", a_flags); end
        tick;
        checks++; if (a_flags !== 6'b100000) begin errors++; $display("FAIL st_edge6 got %b want 100000", a_flags); end
        checks++; if (a_code !== 3'd6 || a_fbeat !== 32'd1) begin
            errors++; $display("FAIL st_capture got %0d/%0d want 6/1", a_code, a_fbeat); end
        sif.tready = 1'b1;
        tick;
        go_idle;
    endtask

    task automatic test_clear_priority;
        do_clear;
        beat(32'h9, 4'b0101, 1'b1);
        checks++; if (a_any !== 1'b1) begin errors++; $display("FAIL cl_pre_any got %b want 1", a_any); end
        sif.tvalid = 1'b1; sif.tready = 1'b1; sif.tdata = 32'hA; sif.tkeep = 4'b0101; sif.tlast = 1'b0;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        go_idle;
        checks++; if (a_flags !== 6'd0 || a_any !== 1'b0 || a_code !== 3'd0) begin
            errors++; $display("FAIL cl_flags got %b/%b/%0d want 000000/0/0", a_flags, a_any, a_code); end
        checks++; if (a_fbeat !== 32'd0 || a_beat !== 32'd0 || a_pkt !== 32'd0 || a_byte !== 32'd0) begin
            errors++; $display("FAIL cl_cnts got %0d/%0d/%0d/%0d want 0/0/0/0", a_fbeat, a_beat, a_pkt, a_byte); end
        // Clear mid-packet must restart packet tracking.
        beat(32'h1, 4'hF, 1'b0);
        beat(32'h2, 4'hF, 1'b0);
        beat(32'h3, 4'hF, 1'b0);
        do_clear;
        beat(32'h4, 4'hF, 1'b0);
        beat(32'h5, 4'hF, 1'b0);
        beat(32'h6, 4'hF, 1'b0);
        beat(32'h7, 4'hF, 1'b1);
        go_idle;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL cl_midpkt_flags got %b want 000000", a_flags); end
        checks++; if (a_pkt !== 32'd1 || a_beat !== 32'd4) begin
            errors++; $display("FAIL cl_midpkt_cnts got %0d/%0d want 1/4", a_pkt, a_beat); end
    endtask

    task automatic test_async_reset;
        beat(32'h1, 4'hF, 1'b0);
        beat(32'h2, 4'hF, 1'b0);
        #2;
        rst = 1'b1;
        go_idle;
        #1;
        checks++; if (a_beat !== 32'd0 || a_pkt !== 32'd0 || a_byte !== 32'd0) begin
            errors++; $display("FAIL ar_cnts got %0d/%0d/%0d want 0/0/0", a_beat, a_pkt, a_byte); end
        tick;
        rst = 1'b0;
        beat(32'h3, 4'hF, 1'b0);
        beat(32'h4, 4'hF, 1'b0);
        beat(32'h5, 4'hF, 1'b0);
        beat(32'h6, 4'hF, 1'b1);
        go_idle;
        checks++; if (a_flags !== 6'd0) begin errors++; $display("FAIL ar_after_flags got %b want 000000", a_flags); end
        checks++; if (a_pkt !== 32'd1 || a_beat !== 32'd4) begin
            errors++; $display("FAIL ar_after_cnts got %0d/%0d want 1/4", a_pkt, a_beat); end
    endtask

    initial begin
        go_idle;
        test_reset;
        test_legal_traffic;
        test_payload_change;
        test_not_packed;
        test_packed_edges;
        test_pkt_too_long;
        test_stall_timeout;
        test_clear_priority;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
